// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the 8x8 LED matrix scan controller.
package led_matrix_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam logic [COLS-1:0] COL_OFF = 8'hFF;

    function automatic logic [ROWS-1:0] row_onehot(input logic [2:0] idx);
        logic [ROWS-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/led_matrix_scan_ctrl_if.sv
// Writer port of the LED matrix scan controller: row beats into the back buffer.
interface led_matrix_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       wr_last;

    modport master (output wr_valid, wr_row, wr_data, wr_last, input wr_ready);
    modport slave  (input wr_valid, wr_row, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/led_frame_dbuf.sv
// Double-buffered 8x8 frame store: writes go to the back bank, reads come from the front bank.
module led_frame_dbuf
    import led_matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [2:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            swap,
    input  logic [2:0]      rd_row,
    output logic [COLS-1:0] rd_data
);
    logic [1:0][ROWS-1:0][COLS-1:0] bank_q, bank_d;
    logic                           front_sel_q, front_sel_d;

    always_comb begin
        bank_d      = bank_q;
        front_sel_d = front_sel_q ^ swap;
        if (wr_en) begin
            bank_d[~front_sel_q][wr_row] = wr_data;
        end
        // On the swap edge the row being loaded must already come from the new front.
        rd_data = bank_q[front_sel_q ^ swap][rd_row];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q      <= '0;
            front_sel_q <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            front_sel_q <= front_sel_d;
        end
    end
endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan controller with blanking and frame-boundary buffer swap.
// Optional macro BRIGHTNESS_PWM_EN adds a 4-bit per-frame brightness input.
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROW_CYCLES   = 65536,
    parameter int BLANK_CYCLES = 64,
    parameter int CNT_W        = 17
) (
    input  logic                   clk_50m,
    input  logic                   reset,
    led_matrix_scan_ctrl_if.slave  wr,
`ifdef BRIGHTNESS_PWM_EN
    input  logic [3:0]             brightness,
`endif
    output logic [ROWS-1:0]        led_row,
    output logic [COLS-1:0]        led_col,
    output logic                   frame_start,
    output logic                   swap_done
);
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    scan_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      row_idx_q, row_idx_d;
    logic            swap_pending_q, swap_pending_d;
    logic [ROWS-1:0] led_row_q, led_row_d;
    logic [COLS-1:0] led_col_q, led_col_d;
    logic            frame_start_q, frame_start_d;
    logic            swap_done_q, swap_done_d;
    logic            accept, swap, enter_show, col_en;
    logic [COLS-1:0] rd_data;

    assign accept      = wr.wr_valid && !swap_pending_q;
    assign wr.wr_ready = ~swap_pending_q;

    // Next scan position; BLANK_CYCLES == 0 chains SHOW straight into SHOW.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        row_idx_d  = row_idx_q;
        swap       = 1'b0;
        enter_show = 1'b0;
        case (state_q)
            BLANK: begin
                if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
                    state_d    = SHOW;
                    cnt_d      = '0;
                    enter_show = 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == ROW_LAST) begin
                    cnt_d     = '0;
                    row_idx_d = row_idx_q + 1'b1;
                    if (row_idx_q == 3'd7) begin
                        swap = swap_pending_q;
                    end
                    if (BLANK_CYCLES == 0) begin
                        enter_show = 1'b1;
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            default: state_d = BLANK;
        endcase
    end

    always_comb begin
        swap_pending_d = swap_pending_q;
        if (swap) begin
            swap_pending_d = 1'b0;
        end else if (accept && wr.wr_last) begin
            swap_pending_d = 1'b1;
        end
        frame_start_d = enter_show && (row_idx_d == 3'd0);
        swap_done_d   = swap;
    end

`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] bright_q, bright_d;

    function automatic logic [31:0] pwm_limit(input logic [3:0] b);
        return ((32'(b) + 32'd1) * 32'(ROW_CYCLES)) >> 4;
    endfunction

    always_comb begin
        bright_d = frame_start_d ? brightness : bright_q;
        col_en   = 32'(cnt_d) < pwm_limit(bright_d);
    end

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) bright_q <= 4'hF;
        else       bright_q <= bright_d;
    end
`else
    assign col_en = 1'b1;
`endif

    always_comb begin
        led_row_d = (state_d == SHOW) ? row_onehot(row_idx_d) : '0;
        led_col_d = (state_d == SHOW && col_en) ? ~rd_data : COL_OFF;
    end

    led_frame_dbuf u_dbuf (
        .clk     (clk_50m),
        .rst     (reset),
        .wr_en   (accept),
        .wr_row  (wr.wr_row),
        .wr_data (wr.wr_data),
        .swap    (swap),
        .rd_row  (row_idx_d),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state_q        <= BLANK;
            cnt_q          <= '0;
            row_idx_q      <= '0;
            swap_pending_q <= 1'b0;
            led_row_q      <= '0;
            led_col_q      <= COL_OFF;
            frame_start_q  <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            row_idx_q      <= row_idx_d;
            swap_pending_q <= swap_pending_d;
            led_row_q      <= led_row_d;
            led_col_q      <= led_col_d;
            frame_start_q  <= frame_start_d;
            swap_done_q    <= swap_done_d;
        end
    end

    assign led_row     = led_row_q;
    assign led_col     = led_col_q;
    assign frame_start = frame_start_q;
    assign swap_done   = swap_done_q;
endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl; expected row columns are queued at commit time.
module tb_led_matrix_scan_ctrl;
    localparam int BLANK_CYCLES = 2;
`ifdef BRIGHTNESS_PWM_EN
    localparam int ROW_CYCLES = 16;
`else
    localparam int ROW_CYCLES = 8;
`endif
    localparam int PERIOD = ROW_CYCLES + BLANK_CYCLES;
    localparam int FRAME  = 8 * PERIOD;
    localparam int BOUND  = 3 * FRAME;

    logic       clk_50m = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] led_row, led_col;
    logic       frame_start, swap_done;
`ifdef BRIGHTNESS_PWM_EN
    logic [3:0] brightness = 4'd3;
`endif

    led_matrix_scan_ctrl_if wif();

    led_matrix_scan_ctrl #(
        .ROW_CYCLES   (ROW_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES),
        .CNT_W        (5)
    ) dut (
        .clk_50m     (clk_50m),
        .reset       (reset),
        .wr          (wif),
`ifdef BRIGHTNESS_PWM_EN
        .brightness  (brightness),
`endif
        .led_row     (led_row),
        .led_col     (led_col),
        .frame_start (frame_start),
        .swap_done   (swap_done)
    );

    always #5 clk_50m = ~clk_50m;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb_q[$];
    logic [7:0] obs_row [8];
    logic [7:0] obs_col [8];

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] d, input logic last);
        int n = 0;
        wif.wr_valid = 1'b1;
        wif.wr_row   = r;
        wif.wr_data  = d;
        wif.wr_last  = last;
        while (wif.wr_ready !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_timeout: row %0d never accepted after %0d cycles", r, n);
        end
        tick();
        wif.wr_valid = 1'b0;
        wif.wr_last  = 1'b0;
    endtask

    task automatic write_frame(input logic [7:0] f [8]);
        for (int r = 0; r < 8; r++) begin
            sb_q.push_back(~f[r]);
            write_row(3'(r), f[r], r == 7);
        end
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < BOUND);
    endtask

    task automatic capture_frame(output int wait_n);
        wait_fs(wait_n);
        for (int r = 0; r < 8; r++) begin
            obs_row[r] = led_row;
            obs_col[r] = led_col;
            if (r < 7) repeat (PERIOD) tick();
        end
    endtask

    task automatic test_reset();
        int n;
        n_cmp++;
        if (led_row !== 8'h00 || led_col !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_leds: got row=%h col=%h want row=00 col=FF", led_row, led_col);
        end
        n_cmp++;
        if (frame_start !== 1'b0 || swap_done !== 1'b0 || wif.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctrl: got fs=%b sd=%b rdy=%b want 0 0 1", frame_start, swap_done, wif.wr_ready);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (led_row !== 8'h00 || frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL first_blank: got row=%h fs=%b want 00 0", led_row, frame_start);
        end
        tick();
        n_cmp++;
        if (led_row !== 8'h01 || led_col !== 8'hFF || frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL first_show: got row=%h col=%h fs=%b want 01 FF 1", led_row, led_col, frame_start);
        end
        repeat (ROW_CYCLES - 1) tick();
        n_cmp++;
        if (led_row !== 8'h01) begin
            n_bad++;
            $display("FAIL show_dwell_end: got row=%h want 01", led_row);
        end
        tick();
        n_cmp++;
        if (led_row !== 8'h00 || led_col !== 8'hFF) begin
            n_bad++;
            $display("FAIL inter_row_blank: got row=%h col=%h want 00 FF", led_row, led_col);
        end
        wait_fs(n);
        n_cmp++;
        if (n + ROW_CYCLES !== FRAME) begin
            n_bad++;
            $display("FAIL frame_period: got %0d want %0d", n + ROW_CYCLES, FRAME);
        end
    endtask

    task automatic test_commit();
        logic [7:0] fa [8] = '{8'h0E, 8'h11, 8'h13, 8'h15, 8'h19, 8'h11, 8'h0E, 8'h00};
        logic [7:0] exp;
        int n = 0;
        int wn;
        bit early = 0;
        write_frame(fa);
        n_cmp++;
        if (wif.wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL commit_ready_drop: got %b want 0", wif.wr_ready);
        end
        while (swap_done !== 1'b1 && n < BOUND) begin
            if (wif.wr_ready !== 1'b0) early = 1;
            tick();
            n++;
        end
        n_cmp++;
        if (early || n >= BOUND) begin
            n_bad++;
            $display("FAIL commit_swap: got early_ready=%0d wait=%0d want no early ready, swap within %0d", early, n, BOUND);
        end
        n_cmp++;
        if (led_row !== 8'h00 || wif.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL swap_at_wrap: got row=%h rdy=%b want 00 1", led_row, wif.wr_ready);
        end
        capture_frame(wn);
        n_cmp++;
        if (wn !== BLANK_CYCLES) begin
            n_bad++;
            $display("FAIL swap_to_frame_start: got %0d want %0d", wn, BLANK_CYCLES);
        end
        for (int r = 0; r < 8; r++) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_cmp++;
            if (obs_row[r] !== (8'h01 << r) || obs_col[r] !== exp) begin
                n_bad++;
                $display("FAIL frame_a_row%0d: got row=%h col=%h want row=%h col=%h", r, obs_row[r], obs_col[r], 8'h01 << r, exp);
            end
        end
    endtask

    task automatic test_hold_pending();
        logic [7:0] fb [8] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
        logic [7:0] exp;
        int n = 0;
        int wn;
        bit early = 0;
        write_frame(fb);
        wif.wr_valid = 1'b1;
        wif.wr_row   = 3'd2;
        wif.wr_data  = 8'hAA;
        wif.wr_last  = 1'b0;
        while (swap_done !== 1'b1 && n < BOUND) begin
            if (wif.wr_ready !== 1'b0) early = 1;
            tick();
            n++;
        end
        n_cmp++;
        if (early || n >= BOUND) begin
            n_bad++;
            $display("FAIL hold_no_handshake: got early_ready=%0d wait=%0d want none, swap within %0d", early, n, BOUND);
        end
        n_cmp++;
        if (wif.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_ready_after_swap: got %b want 1", wif.wr_ready);
        end
        tick();
        wif.wr_valid = 1'b0;
        capture_frame(wn);
        for (int r = 0; r < 8; r++) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_cmp++;
            if (obs_row[r] !== (8'h01 << r) || obs_col[r] !== exp) begin
                n_bad++;
                $display("FAIL frame_b_row%0d: got row=%h col=%h want row=%h col=%h", r, obs_row[r], obs_col[r], 8'h01 << r, exp);
            end
        end
    endtask

    task automatic test_commit_on_wrap();
        logic [7:0] fc [8] = '{8'h0E, 8'h11, 8'hAA, 8'h15, 8'h19, 8'h11, 8'h0E, 8'h5A};
        logic [7:0] exp;
        int n = 0;
        int wn;
        wait_fs(wn);
        repeat (7 * PERIOD + ROW_CYCLES - 1) tick();
        n_cmp++;
        if (led_row !== 8'h80 || wif.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_setup: got row=%h rdy=%b want 80 1", led_row, wif.wr_ready);
        end
        for (int r = 0; r < 8; r++) sb_q.push_back(~fc[r]);
        wif.wr_valid = 1'b1;
        wif.wr_row   = 3'd7;
        wif.wr_data  = 8'h5A;
        wif.wr_last  = 1'b1;
        tick();
        wif.wr_valid = 1'b0;
        wif.wr_last  = 1'b0;
        n_cmp++;
        if (wif.wr_ready !== 1'b0 || swap_done !== 1'b0 || led_row !== 8'h00) begin
            n_bad++;
            $display("FAIL wrap_commit_no_swap: got rdy=%b sd=%b row=%h want 0 0 00", wif.wr_ready, swap_done, led_row);
        end
        do begin
            tick();
            n++;
        end while (swap_done !== 1'b1 && n < BOUND);
        n_cmp++;
        if (n !== FRAME) begin
            n_bad++;
            $display("FAIL wrap_swap_delay: got %0d want %0d", n, FRAME);
        end
        capture_frame(wn);
        for (int r = 0; r < 8; r++) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_cmp++;
            if (obs_row[r] !== (8'h01 << r) || obs_col[r] !== exp) begin
                n_bad++;
                $display("FAIL frame_c_row%0d: got row=%h col=%h want row=%h col=%h", r, obs_row[r], obs_col[r], 8'h01 << r, exp);
            end
        end
    endtask

`ifdef BRIGHTNESS_PWM_EN
    task automatic test_pwm();
        int wn;
        int on_n = 0, off_n = 0, row_n = 0;
        wait_fs(wn);
        for (int i = 0; i < ROW_CYCLES; i++) begin
            if (led_row === 8'h01) row_n++;
            if (led_col === 8'hF1) on_n++;
            if (led_col === 8'hFF) off_n++;
            tick();
        end
        n_cmp++;
        if (on_n !== 4 || off_n !== 12 || row_n !== 16) begin
            n_bad++;
            $display("FAIL pwm_duty: got on=%0d off=%0d row=%0d want 4 12 16", on_n, off_n, row_n);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [7:0] exp;
        int n = 0;
        int wn;
        wait_fs(wn);
        write_row(3'd0, 8'h3C, 1'b1);
        n_cmp++;
        if (wif.wr_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_pending: got rdy=%b want 0", wif.wr_ready);
        end
        while (led_row !== 8'h20 && n < BOUND) begin
            tick();
            n++;
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (led_row !== 8'h00 || led_col !== 8'hFF || wif.wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got row=%h col=%h rdy=%b want 00 FF 1", led_row, led_col, wif.wr_ready);
        end
        tick();
        reset = 1'b0;
        for (int r = 0; r < 8; r++) sb_q.push_back(8'hFF);
        capture_frame(wn);
        n_cmp++;
        if (wn !== BLANK_CYCLES) begin
            n_bad++;
            $display("FAIL restart_latency: got %0d want %0d", wn, BLANK_CYCLES);
        end
        for (int r = 0; r < 8; r++) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_cmp++;
            if (obs_row[r] !== (8'h01 << r) || obs_col[r] !== exp) begin
                n_bad++;
                $display("FAIL restart_row%0d: got row=%h col=%h want row=%h col=%h", r, obs_row[r], obs_col[r], 8'h01 << r, exp);
            end
        end
    endtask

    initial begin
        wif.wr_valid = 1'b0;
        wif.wr_row   = '0;
        wif.wr_data  = '0;
        wif.wr_last  = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        test_reset();
        test_commit();
        test_hold_pending();
        test_commit_on_wrap();
`ifdef BRIGHTNESS_PWM_EN
        test_pwm();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
